// File: rtl/harness_serial_frame_controller.sv
// Serial test-frame sequencer: deserialises DUT operands, applies them atomically,
// waits a fixed latency, captures the DUT results and serialises them back out.
module harness_serial_frame_controller #(
    parameter int WORD_WIDTH   = 36,
    parameter int IN_CHANNELS  = 3,
    parameter int OUT_CHANNELS = 1,
    parameter int SERIAL_WIDTH = 1,
    parameter int DUT_LATENCY  = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [SERIAL_WIDTH-1:0]             serial_in,
    output logic [SERIAL_WIDTH-1:0]             serial_out,
    output logic                                busy,
    output logic                                done,
    output logic [15:0]                         frame_count,
    output logic [IN_CHANNELS*WORD_WIDTH-1:0]   dut_in,
    input  logic [OUT_CHANNELS*WORD_WIDTH-1:0]  dut_out
);

    localparam int IN_W      = IN_CHANNELS * WORD_WIDTH;
    localparam int OUT_W     = OUT_CHANNELS * WORD_WIDTH;
    localparam int IN_BEATS  = IN_W / SERIAL_WIDTH;
    localparam int OUT_BEATS = OUT_W / SERIAL_WIDTH;
    localparam int MAX_IO    = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
    localparam int MAX_BEATS = (MAX_IO > DUT_LATENCY) ? MAX_IO : DUT_LATENCY;
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BEATS - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BEATS - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

    if (WORD_WIDTH % SERIAL_WIDTH != 0) begin : g_bad_serial_width
        $error("WORD_WIDTH must be a multiple of SERIAL_WIDTH");
    end
    if (DUT_LATENCY < 0 || DUT_LATENCY > 255) begin : g_bad_latency
        $error("DUT_LATENCY must be in 0..255");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_APPLY     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_SHIFT_OUT = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IN_W-1:0]         shadow_q, shadow_d;
    logic [IN_W-1:0]         dut_in_q, dut_in_d;
    logic [OUT_W-1:0]        result_q, result_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [IN_W+SERIAL_WIDTH-1:0] shadow_cat;

    // New beats enter at the top of the shadow chain and walk toward the LSB.
    assign shadow_cat = {serial_in, shadow_q};

    // Next-state and datapath update for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        dut_in_d      = dut_in_q;
        result_d      = result_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT_IN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_SHIFT_IN: begin
                shadow_d = shadow_cat[IN_W+SERIAL_WIDTH-1:SERIAL_WIDTH];
                if (cnt_q == IN_LAST) begin
                    state_d = ST_APPLY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_APPLY: begin
                dut_in_d = shadow_q;
                cnt_d    = '0;
                if (DUT_LATENCY > 0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                result_d = dut_out;
                cnt_d    = '0;
                state_d  = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                result_d = result_q >> SERIAL_WIDTH;
                if (cnt_q == OUT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                cnt_d         = '0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            dut_in_q      <= '0;
            result_q      <= '0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            dut_in_q      <= dut_in_d;
            result_q      <= result_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Status and serial output decode from registered state only.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
        if (state_q == ST_SHIFT_OUT) begin
            serial_out = result_q[SERIAL_WIDTH-1:0];
        end else begin
            serial_out = '0;
        end
    end

    assign dut_in      = dut_in_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_harness_serial_frame_controller.sv
// Scoreboard bench for harness_serial_frame_controller: a narrow 8-bit instance with
// latency 1 and a 36-bit, 4-bit-beat instance with latency 0.
module tb_harness_serial_frame_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        a_start = 1'b0;
    logic [0:0]  a_serial_in = 1'b0;
    logic [0:0]  a_serial_out;
    logic        a_busy, a_done;
    logic [15:0] a_frame_count;
    logic [23:0] a_dut_in;
    logic [7:0]  a_dut_out;

    logic         b_start = 1'b0;
    logic [3:0]   b_serial_in = 4'd0;
    logic [3:0]   b_serial_out;
    logic         b_busy, b_done;
    logic [15:0]  b_frame_count;
    logic [107:0] b_dut_in;
    logic [35:0]  b_dut_out;

    int errors = 0;
    int checks = 0;
    int exp_fc = 0;
    logic [7:0]  exp_q[$];
    logic [35:0] exp36_q[$];

    always #5 clock = ~clock;

    assign a_dut_out = a_dut_in[7:0] ^ a_dut_in[15:8];
    assign b_dut_out = b_dut_in[35:0] ^ b_dut_in[107:72];

    harness_serial_frame_controller #(
        .WORD_WIDTH(8), .IN_CHANNELS(3), .OUT_CHANNELS(1), .SERIAL_WIDTH(1), .DUT_LATENCY(1)
    ) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .serial_in(a_serial_in),
        .serial_out(a_serial_out), .busy(a_busy), .done(a_done),
        .frame_count(a_frame_count), .dut_in(a_dut_in), .dut_out(a_dut_out)
    );

    harness_serial_frame_controller #(
        .WORD_WIDTH(36), .IN_CHANNELS(3), .OUT_CHANNELS(1), .SERIAL_WIDTH(4), .DUT_LATENCY(0)
    ) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .serial_in(b_serial_in),
        .serial_out(b_serial_out), .busy(b_busy), .done(b_done),
        .frame_count(b_frame_count), .dut_in(b_dut_in), .dut_out(b_dut_out)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One frame on the narrow instance; count = edges since the start-sampling edge.
    task automatic frame_a(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input bit junk_start, input bit check_hold, input logic [23:0] hold_val);
        logic [23:0] word;
        logic [7:0]  got;
        logic [7:0]  exp;
        int cnt;
        bit seen;
        word = {c2, c1, c0};
        exp_q.push_back(c0 ^ c1);
        got  = 8'd0;
        seen = 1'b0;
        cnt  = 0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        while (cnt < 60 && !seen) begin
            if (cnt < 24) a_serial_in = word[cnt];
            else          a_serial_in = 1'($urandom);
            a_start = junk_start && (cnt == 5 || cnt == 25);
            step();
            cnt++;
            if (check_hold && cnt <= 24) begin
                checks++;
                if (a_dut_in !== hold_val) begin
                    errors++;
                    $display("FAIL dut_in_hold cycle %0d: got %h expected %h", cnt, a_dut_in, hold_val);
                end
            end
            if (cnt == 10) begin
                checks++;
                if (a_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_frame: got %b expected 1", a_busy);
                end
            end
            if (cnt == 25) begin
                checks++;
                if (a_dut_in !== word) begin
                    errors++;
                    $display("FAIL dut_in_apply: got %h expected %h", a_dut_in, word);
                end
            end
            if (cnt == 26) begin
                checks++;
                if (a_serial_out !== 1'b0) begin
                    errors++;
                    $display("FAIL serial_out_idle: got %b expected 0", a_serial_out);
                end
            end
            if (cnt >= 27 && cnt <= 34) got[cnt-27] = a_serial_out[0];
            if (a_done === 1'b1) seen = 1'b1;
        end
        a_start = 1'b0;
        checks++;
        if (!seen || cnt != 35) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles (seen=%0d) expected 35", cnt, seen);
        end
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL serial_result: got %h expected %h", got, exp);
        end
        exp_fc = (exp_fc + 1) & 16'hFFFF;
        a_start = junk_start;
        step();
        a_start = 1'b0;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_done: got done=%b busy=%b expected 0 0", a_done, a_busy);
        end
        step();
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_start: got busy=%b expected 0", a_busy);
        end
    endtask

    // One frame on the wide instance (4-bit beats, no latency stage).
    task automatic frame_b(input logic [35:0] c0, input logic [35:0] c1, input logic [35:0] c2);
        logic [107:0] word;
        logic [35:0]  got;
        logic [35:0]  exp;
        int cnt;
        bit seen;
        word = {c2, c1, c0};
        exp36_q.push_back(c0 ^ c2);
        got  = 36'd0;
        seen = 1'b0;
        cnt  = 0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        while (cnt < 80 && !seen) begin
            if (cnt < 27) b_serial_in = word[cnt*4 +: 4];
            else          b_serial_in = 4'($urandom);
            step();
            cnt++;
            if (cnt == 28) begin
                checks++;
                if (b_dut_in !== word) begin
                    errors++;
                    $display("FAIL wide_dut_in: got %h expected %h", b_dut_in, word);
                end
            end
            if (cnt >= 29 && cnt <= 37) got[(cnt-29)*4 +: 4] = b_serial_out;
            if (b_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cnt != 38) begin
            errors++;
            $display("FAIL wide_done_latency: got %0d cycles (seen=%0d) expected 38", cnt, seen);
        end
        exp = exp36_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wide_result: got %h expected %h", got, exp);
        end
        step();
    endtask

    task automatic check_fc(input string name);
        checks++;
        if (a_frame_count !== 16'(exp_fc)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a_frame_count, 16'(exp_fc));
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_serial_out !== 1'b0 ||
            a_frame_count !== 16'd0 || a_dut_in !== 24'd0 ||
            b_busy !== 1'b0 || b_dut_in !== 108'd0 || b_frame_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b so=%b fc=%h din=%h expected all 0",
                     a_busy, a_done, a_serial_out, a_frame_count, a_dut_in);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        frame_a(8'hA5, 8'h3C, 8'hFF, 1'b0, 1'b0, 24'd0);
        check_fc("frame_count_basic");
    endtask

    task automatic test_hold();
        frame_a(8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 24'hFF3CA5);
        check_fc("frame_count_hold");
    endtask

    task automatic test_start_ignored();
        frame_a(8'h0F, 8'hF0, 8'h81, 1'b1, 1'b1, 24'h563412);
        check_fc("frame_count_ignore_start");
    endtask

    task automatic test_reset_mid();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_serial_in = 1'b1;
            step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_dut_in !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b dut_in=%h expected 0 0", a_busy, a_dut_in);
        end
        exp_fc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got %b expected 0", a_done);
            end
        end
        reset = 1'b0;
        step();
        check_fc("frame_count_after_reset");
        frame_a(8'h01, 8'h80, 8'h7E, 1'b0, 1'b0, 24'd0);
        check_fc("frame_count_after_recover");
    endtask

    task automatic test_wide();
        frame_b(36'h123456789, 36'hFEDCBA987, 36'h0F0F0F0F0);
        frame_b(36'hFFFFFFFFF, 36'h000000001, 36'h5A5A5A5A5);
    endtask

    task automatic test_wrap();
        force dut_a.frame_count_q = 16'hFFFF;
        step();
        step();
        release dut_a.frame_count_q;
        step();
        exp_fc = 16'hFFFF;
        check_fc("frame_count_preload");
        frame_a(8'hC3, 8'h3C, 8'h00, 1'b0, 1'b0, 24'd0);
        check_fc("frame_count_wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_start_ignored();
        test_reset_mid();
        test_wide();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
